restoring_divider_8: RTL and testbench



---
 rtl/restoring_divider_8_pkg.sv | 13 +
 rtl/trial_subtractor_9.sv | 37 +++
 rtl/restoring_divider_8.sv | 119 +++++++++++
 tb/tb_restoring_divider_8.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/restoring_divider_8_pkg.sv
// Shared types and defaults for the restoring divider.
package div_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/trial_subtractor_9.sv
// Ripple subtractor a - b built from full-adder cells: b is inverted and the
// carry chain starts at 1. A carry out of 1 means a >= b, so borrow is its inverse.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module trial_subtractor_9 #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);
    logic [N:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < N; i++) begin : g_cell
        full_adder u_fa (
            .a   (a[i]),
            .b   (~b[i]),
            .cin (carry[i]),
            .sum (diff[i]),
            .cout(carry[i+1])
        );
    end

    assign borrow = ~carry[N];
endmodule

// File: rtl/restoring_divider_8.sv
// Sequential unsigned restoring divider: one quotient bit per clock.
// Run is edge-detected; results appear only on entry to DONE.
// state_dbg exposes the FSM state for observation.
module restoring_divider_8
    import div_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEFAULT,
    parameter int ITER_W = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivByZero,
    output logic             Busy,
    output logic             Done,
    output div_state_t       state_dbg
);
    div_state_t        state, state_next;
    logic [WIDTH:0]    r_reg;
    logic [WIDTH-1:0]  q_reg;
    logic [WIDTH-1:0]  d_reg;
    logic [ITER_W-1:0] cnt;
    logic              run_prev;

    logic [WIDTH:0]    shifted;
    logic [WIDTH:0]    diff;
    logic              borrow;
    logic [WIDTH:0]    r_next;
    logic [WIDTH-1:0]  q_next;
    logic              last_iter;

    // Shift the next dividend bit into the partial remainder and try subtracting D.
    assign shifted   = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    assign r_next    = borrow ? shifted : diff;
    assign q_next    = {q_reg[WIDTH-2:0], ~borrow};
    assign last_iter = (cnt == ITER_W'(WIDTH - 1));
    assign state_dbg = state;

    trial_subtractor_9 #(.N(WIDTH + 1)) u_sub (
        .a     (shifted),
        .b     ({1'b0, d_reg}),
        .diff  (diff),
        .borrow(borrow)
    );

    // FSM state register; Reset wins over everything.
    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_next = state;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state)
            IDLE: if (Run && !run_prev) state_next = LOAD;
            LOAD: begin
                Busy       = 1'b1;
                state_next = (Divisor == '0) ? DONE : ITER;
            end
            ITER: begin
                Busy = 1'b1;
                if (last_iter) state_next = DONE;
            end
            DONE: begin
                Done = 1'b1;
                if (!Run) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand latch, shift/subtract/restore, result capture, Run history.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_reg     <= '0;
            q_reg     <= '0;
            d_reg     <= '0;
            cnt       <= '0;
            run_prev  <= 1'b0;
            Quotient  <= '0;
            Remainder <= '0;
            DivByZero <= 1'b0;
        end else begin
            run_prev <= Run;
            case (state)
                LOAD: begin
                    d_reg <= Divisor;
                    q_reg <= Dividend;
                    r_reg <= '0;
                    cnt   <= '0;
                    if (Divisor == '0) begin
                        Quotient  <= '1;
                        Remainder <= Dividend;
                        DivByZero <= 1'b1;
                    end else begin
                        DivByZero <= 1'b0;
                    end
                end
                ITER: begin
                    r_reg <= r_next;
                    q_reg <= q_next;
                    cnt   <= cnt + ITER_W'(1);
                    if (last_iter) begin
                        Quotient  <= q_next;
                        Remainder <= r_next[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_restoring_divider_8.sv
// Directed and swept checks of restoring_divider_8; all activity on the falling edge.
module tb_restoring_divider_8;
    import div_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;
    logic       busy;
    logic       done;
    div_state_t state_dbg;

    int checks   = 0;
    int failures = 0;

    // Last result the DUT should be presenting while idle or working.
    logic [7:0] prev_q = 8'd0;
    logic [7:0] prev_r = 8'd0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    restoring_divider_8 dut (
        .Clk      (clk),
        .Reset    (reset),
        .Run      (run),
        .Dividend (dividend),
        .Divisor  (divisor),
        .Quotient (quotient),
        .Remainder(remainder),
        .DivByZero(div_by_zero),
        .Busy     (busy),
        .Done     (done),
        .state_dbg(state_dbg)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // One full operation: raise Run, wait for Done (bounded), check timing and results.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er, input logic edz,
                          input string tag, input bit scramble);
        int edges    = 0;
        int busy_cnt = 0;
        int stable   = 1;
        dividend = a;
        divisor  = b;
        run      = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            edges = i;
            if (busy) busy_cnt++;
            if (done) break;
            if (quotient !== prev_q || remainder !== prev_r) stable = 0;
            if (scramble && i == 2) begin
                dividend = 8'($urandom_range(0, 255));
                divisor  = 8'($urandom_range(0, 255));
            end
        end
        check({tag, "_latency"},  edges,    (b == 8'd0) ? 2 : 10);
        check({tag, "_busy_cyc"}, busy_cnt, (b == 8'd0) ? 1 : 9);
        check({tag, "_done"},     int'(done), 1);
        check({tag, "_quot"},     int'(quotient), int'(eq));
        check({tag, "_rem"},      int'(remainder), int'(er));
        check({tag, "_dz"},       int'(div_by_zero), int'(edz));
        check({tag, "_stable"},   stable, 1);
        run = 1'b0;
        @(negedge clk);
        check({tag, "_idle"}, int'(state_dbg), int'(IDLE));
        prev_q = eq;
        prev_r = er;
    endtask

    initial begin
        vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0};
        vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0};
        vecs[2] = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0};
        vecs[3] = '{8'd5,   8'd9,   8'd0,   8'd5,  1'b0};
        vecs[4] = '{8'd0,   8'd3,   8'd0,   8'd0,  1'b0};
        vecs[5] = '{8'd37,  8'd0,   8'd255, 8'd37, 1'b1};
        vecs[6] = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0};
        vecs[7] = '{8'd200, 8'd13,  8'd15,  8'd5,  1'b0};
        vecs[8] = '{8'd128, 8'd16,  8'd8,   8'd0,  1'b0};

        reset    = 1'b1;
        run      = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_state", int'(state_dbg),   int'(IDLE));
        check("rst_quot",  int'(quotient),    0);
        check("rst_rem",   int'(remainder),   0);
        check("rst_dz",    int'(div_by_zero), 0);
        check("rst_busy",  int'(busy),        0);
        check("rst_done",  int'(done),        0);
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i])
            run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz,
                   $sformatf("vec%0d", i), 1'b0);

        // Operand switches move right after LOAD; the result must not change.
        run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, "scramble", 1'b1);

        // Run held for 30 cycles starts exactly one operation.
        begin
            int loads = 0;
            dividend = 8'd77;
            divisor  = 8'd10;
            run      = 1'b1;
            repeat (30) begin
                @(negedge clk);
                if (state_dbg == LOAD) loads++;
            end
            check("hold_loads", loads, 1);
            check("hold_done",  int'(done), 1);
            check("hold_quot",  int'(quotient), 7);
            check("hold_rem",   int'(remainder), 7);
            run = 1'b0;
            repeat (2) @(negedge clk);
            check("hold_idle", int'(state_dbg), int'(IDLE));
            prev_q = 8'd7;
            prev_r = 8'd7;
        end

        // Reset during the 4th ITER cycle abandons the operation.
        dividend = 8'd100;
        divisor  = 8'd7;
        run      = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst_in_iter", int'(state_dbg), int'(ITER));
        check("midrst_old_q",   int'(quotient), 7);
        reset = 1'b1;
        run   = 1'b0;
        @(negedge clk);
        check("midrst_state", int'(state_dbg),   int'(IDLE));
        check("midrst_quot",  int'(quotient),    0);
        check("midrst_rem",   int'(remainder),   0);
        check("midrst_dz",    int'(div_by_zero), 0);
        check("midrst_busy",  int'(busy),        0);
        check("midrst_done",  int'(done),        0);
        reset  = 1'b0;
        prev_q = 8'd0;
        prev_r = 8'd0;
        @(negedge clk);
        run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, "after_rst", 1'b0);

        // Random sweep against the division identity.
        for (int n = 0; n < 1000; n++) begin
            logic [7:0] a;
            logic [7:0] b;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(1, 255));
            run_op(a, b, a / b, a % b, 1'b0, "rand", 1'b0);
            check("rand_identity",
                  int'((int'(quotient) * int'(b) + int'(remainder)) == int'(a)
                       && remainder < b), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
